branch_pc_ctrl: RTL

- Fetch-PC sequencer and branch-resolution controller for the 5-stage LEGv8 pipeline.
- Owns the fetch PC register and decodes the ID-stage instruction for B, BL, BR, CBZ, CBNZ and B.cond.
- Forms PC-relative targets from sign-extended imm26/imm19, redirects fetch, and sequences the IF/ID flush bubbles.
- Also requests upstream hold while B.cond waits on pending flags.

---
 rtl/branch_pc_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/branch_pc_ctrl.sv
// rtl/branch_pc_ctrl.sv - LEGv8 fetch-PC sequencer and ID-stage branch resolution
// Optional branch statistics counters: define BRANCH_STATS_EN.
module branch_pc_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [63:0] id_pc,
  input  logic [63:0] id_rn_val,
  input  logic        rt_zero,
  input  logic [3:0]  flags,
  input  logic        flags_valid,
  output logic [63:0] pc_out,
  output logic        flush_ifid,
  output logic        hold_req,
  output logic        link_we,
  output logic [63:0] link_val
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] taken_count
`endif
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_FLAGS, S_FLUSH} state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      r_state, r_state_nxt;
  logic [63:0] r_pc, r_pc_nxt;
  logic        r_flush, r_flush_nxt;
  logic        r_hold, r_hold_nxt;
  logic        r_lwe, r_lwe_nxt;
  logic [63:0] r_lval, r_lval_nxt;
  logic [1:0]  r_cnt, r_cnt_nxt;

  logic        w_is_b, w_is_bl, w_is_cbz, w_is_cbnz, w_is_bcond, w_is_br, w_is_branch;
  logic [63:0] w_off26, w_off19, w_target;
  logic        w_cond_true, w_taken;
  logic        w_act, w_redirect;
  logic        w_n, w_z, w_c, w_v;

  assign w_is_b      = (id_instr[31:26] == 6'b000101);
  assign w_is_bl     = (id_instr[31:26] == 6'b100101);
  assign w_is_cbz    = (id_instr[31:24] == 8'b10110100);
  assign w_is_cbnz   = (id_instr[31:24] == 8'b10110101);
  assign w_is_bcond  = (id_instr[31:24] == 8'b01010100);
  assign w_is_br     = (id_instr[31:10] == 22'b1101011000011111000000) && (id_instr[4:0] == 5'd0);
  assign w_is_branch = w_is_b | w_is_bl | w_is_cbz | w_is_cbnz | w_is_bcond | w_is_br;

  assign w_off26  = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
  assign w_off19  = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};
  assign w_target = w_is_br ? id_rn_val :
                    (w_is_b | w_is_bl) ? (id_pc + w_off26) : (id_pc + w_off19);

  assign {w_n, w_z, w_c, w_v} = flags;

  always_comb begin
    w_cond_true = 1'b0;
    case (id_instr[3:0])
      4'h0: w_cond_true = w_z;
      4'h1: w_cond_true = !w_z;
      4'h2: w_cond_true = w_c;
      4'h3: w_cond_true = !w_c;
      4'h4: w_cond_true = w_n;
      4'h5: w_cond_true = !w_n;
      4'h6: w_cond_true = w_v;
      4'h7: w_cond_true = !w_v;
      4'h8: w_cond_true = w_c & !w_z;
      4'h9: w_cond_true = !(w_c & !w_z);
      4'hA: w_cond_true = (w_n == w_v);
      4'hB: w_cond_true = (w_n != w_v);
      4'hC: w_cond_true = !w_z & (w_n == w_v);
      4'hD: w_cond_true = !(!w_z & (w_n == w_v));
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_taken = w_is_b | w_is_bl | w_is_br | (w_is_cbz & rt_zero) |
                   (w_is_cbnz & !rt_zero) | (w_is_bcond & w_cond_true);

  always_comb begin
    r_state_nxt = r_state;
    r_pc_nxt    = r_pc;
    r_flush_nxt = r_flush;
    r_hold_nxt  = r_hold;
    r_lwe_nxt   = 1'b0;
    r_lval_nxt  = r_lval;
    r_cnt_nxt   = r_cnt;
    w_act       = 1'b0;
    w_redirect  = 1'b0;
    if (!stall) begin
      case (r_state)
        S_RUN: begin
          if (id_valid && w_is_bcond && !flags_valid) begin
            r_state_nxt = S_WAIT_FLAGS;
            r_hold_nxt  = 1'b1;
            r_flush_nxt = 1'b0;
          end else begin
            w_act      = 1'b1;
            w_redirect = id_valid && w_taken;
          end
        end
        S_WAIT_FLAGS: begin
          if (flags_valid) begin
            r_hold_nxt  = 1'b0;
            r_state_nxt = S_RUN;
            w_act       = 1'b1;
            w_redirect  = w_taken;
          end
        end
        S_FLUSH: begin
          r_pc_nxt = r_pc + 64'd4;
          if (r_cnt == 2'd0) begin
            r_flush_nxt = 1'b0;
            r_state_nxt = S_RUN;
          end else begin
            r_cnt_nxt = r_cnt - 2'd1;
          end
        end
        default: r_state_nxt = S_RUN;
      endcase
      // Shared taken/not-taken action for RUN decisions and flag-wait resolution
      if (w_act) begin
        if (w_redirect) begin
          r_pc_nxt    = w_target;
          r_flush_nxt = 1'b1;
          r_cnt_nxt   = CNT_INIT;
          r_state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
          if (w_is_bl) begin
            r_lwe_nxt  = 1'b1;
            r_lval_nxt = id_pc + 64'd4;
          end
        end else begin
          r_pc_nxt    = r_pc + 64'd4;
          r_flush_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= 64'd0;
      r_flush <= 1'b0;
      r_hold  <= 1'b0;
      r_lwe   <= 1'b0;
      r_lval  <= 64'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= r_state_nxt;
      r_pc    <= r_pc_nxt;
      r_flush <= r_flush_nxt;
      r_hold  <= r_hold_nxt;
      r_lwe   <= r_lwe_nxt;
      r_lval  <= r_lval_nxt;
      r_cnt   <= r_cnt_nxt;
    end
  end

  assign pc_out     = r_pc;
  assign flush_ifid = r_flush;
  assign hold_req   = r_hold;
  assign link_we    = r_lwe;
  assign link_val   = r_lval;

`ifdef BRANCH_STATS_EN
  logic        w_resolve;
  logic [31:0] r_br_cnt, r_taken_cnt;

  // A flag-wait entry is not a decision; it is counted once when resolved
  assign w_resolve = !stall &&
                     ((r_state == S_RUN && id_valid && w_is_branch && !(w_is_bcond && !flags_valid)) ||
                      (r_state == S_WAIT_FLAGS && flags_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_br_cnt    <= 32'd0;
      r_taken_cnt <= 32'd0;
    end else begin
      if (w_resolve) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_act && w_redirect) r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end

  assign br_count    = r_br_cnt;
  assign taken_count = r_taken_cnt;
`endif

endmodule
